// File: rtl/ram_responder.sv
// Byte-addressable big-endian RAM that answers the CPU's MOV/RW/MOC four-phase handshake.
// Optional misalignment flagging is enabled by defining RAM_ALIGN_CHECK_EN.
module ram_responder #(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ram_enable,
    input  logic        mov,
    input  logic        rw,
    input  logic [1:0]  size,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        moc,
    output logic        err
);
    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic                    rw_q;
    logic [1:0]              size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;

    logic [7:0]              mem [Depth];

    logic [ADDR_WIDTH-1:0]   a0, a1, a2, a3;
    logic [31:0]             rdata;
    logic                    acc_err;
    logic                    access;
    logic                    unused_addr_hi;

    // Address bits above the memory depth are deliberately dropped (addresses wrap).
    assign unused_addr_hi = ^address[31:ADDR_WIDTH];

    always_comb begin
`ifdef RAM_ALIGN_CHECK_EN
        acc_err = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
        a0      = addr_q;
`else
        acc_err = 1'b0;
        a0      = addr_q;
        if (size_q == 2'b01) begin
            a0[0] = 1'b0;
        end else if (size_q[1]) begin
            a0[1:0] = 2'b00;
        end
`endif
        a1 = a0 + ADDR_WIDTH'(1);
        a2 = a0 + ADDR_WIDTH'(2);
        a3 = a0 + ADDR_WIDTH'(3);
        case (size_q)
            2'b00:   rdata = {24'b0, mem[a0]};
            2'b01:   rdata = {16'b0, mem[a0], mem[a1]};
            default: rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    assign access = (state_q == StWait) && mov && (cnt_q == 4'd0);

    // Storage is intentionally not reset; a write commits on the edge moc rises.
    always_ff @(posedge clk) begin
        if (access && !rw_q && !acc_err) begin
            case (size_q)
                2'b00: begin
                    mem[a0] <= wdata_q[7:0];
                end
                2'b01: begin
                    mem[a0] <= wdata_q[15:8];
                    mem[a1] <= wdata_q[7:0];
                end
                default: begin
                    mem[a0] <= wdata_q[31:24];
                    mem[a1] <= wdata_q[23:16];
                    mem[a2] <= wdata_q[15:8];
                    mem[a3] <= wdata_q[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            rw_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            moc      <= 1'b0;
            err      <= 1'b0;
            data_out <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ram_enable && mov) begin
                        rw_q    <= rw;
                        size_q  <= size;
                        addr_q  <= address[ADDR_WIDTH-1:0];
                        wdata_q <= data_in;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (!mov) begin
                        state_q <= StIdle;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        moc     <= 1'b1;
                        err     <= acc_err;
                        state_q <= StDone;
                        if (acc_err) begin
                            data_out <= 32'd0;
                        end else if (rw_q) begin
                            data_out <= rdata;
                        end
                    end
                end
                StDone: begin
                    if (!mov) begin
                        moc     <= 1'b0;
                        err     <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
